writeback_arbiter: RTL

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

---
 rtl/writeback_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges the ALU and load-unit result channels onto a single
// register-file write port and tracks outstanding destination writes per register.
// Optional feature: define WB_BYPASS_EN to add two forwarding read ports that
// return the write currently on the register-file port.

`ifndef XLEN
`define XLEN 32
`endif

module writeback_arbiter (
  input  logic              i_clk,
  input  logic              i_rst,
  // ALU result channel
  input  logic              i_alu_valid,
  input  logic [4:0]        i_alu_rd,
  input  logic [`XLEN-1:0]  i_alu_data,
  output logic              o_alu_ready,
  // Load-unit result channel
  input  logic              i_lsu_valid,
  input  logic [4:0]        i_lsu_rd,
  input  logic [`XLEN-1:0]  i_lsu_data,
  output logic              o_lsu_ready,
  // Register-file write port
  output logic              o_Wen,
  output logic [4:0]        o_Wnum,
  output logic [`XLEN-1:0]  o_Wd,
  // Issue-stage destination reservation
  input  logic              i_issue,
  input  logic [4:0]        i_issue_rd,
  output logic              o_issue_ready,
  output logic [31:0]       o_busy
`ifdef WB_BYPASS_EN
  ,
  input  logic [4:0]        i_Rnum1,
  input  logic [4:0]        i_Rnum2,
  output logic              o_fwd1_valid,
  output logic [`XLEN-1:0]  o_fwd1_data,
  output logic              o_fwd2_valid,
  output logic [`XLEN-1:0]  o_fwd2_data
`endif
);

  // 1: ALU was granted last, so LSU wins the next conflict.
  logic             alu_last_q;
  logic             wen_q;
  logic [4:0]       wnum_q;
  logic [`XLEN-1:0] wd_q;
  logic [1:0]       cnt_q [32];
  logic [1:0]       cnt_d [32];

  logic             alu_acc;
  logic             lsu_acc;
  logic             inc_en;

  // Round-robin grant; both readies held low while reset is asserted.
  always_comb begin
    o_alu_ready = ~i_rst & i_alu_valid & ~(i_lsu_valid & alu_last_q);
    o_lsu_ready = ~i_rst & i_lsu_valid & ~(i_alu_valid & ~alu_last_q);
    alu_acc     = i_alu_valid & o_alu_ready;
    lsu_acc     = i_lsu_valid & o_lsu_ready;
  end

  // Grant pointer and registered write port.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      alu_last_q <= 1'b1;
      wen_q      <= 1'b0;
      wnum_q     <= '0;
      wd_q       <= '0;
    end else begin
      if (alu_acc) begin
        alu_last_q <= 1'b1;
        wen_q      <= (i_alu_rd != 5'd0);
        wnum_q     <= i_alu_rd;
        wd_q       <= i_alu_data;
      end else if (lsu_acc) begin
        alu_last_q <= 1'b0;
        wen_q      <= (i_lsu_rd != 5'd0);
        wnum_q     <= i_lsu_rd;
        wd_q       <= i_lsu_data;
      end else begin
        wen_q      <= 1'b0;
      end
    end
  end

  assign o_Wen  = wen_q;
  assign o_Wnum = wnum_q;
  assign o_Wd   = wd_q;

  // Issue is refused while its destination counter is saturated.
  always_comb begin
    o_issue_ready = (cnt_q[i_issue_rd] != 2'd3);
    inc_en        = i_issue & o_issue_ready & (i_issue_rd != 5'd0);
  end

  // Pending-counter update; a simultaneous issue and write to one register cancel.
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      cnt_d[i] = cnt_q[i];
      if (i != 0) begin
        if (inc_en && (i_issue_rd == 5'(i)) && !(wen_q && (wnum_q == 5'(i)))) begin
          if (cnt_q[i] != 2'd3) cnt_d[i] = cnt_q[i] + 2'd1;
        end else if (wen_q && (wnum_q == 5'(i)) && !(inc_en && (i_issue_rd == 5'(i)))) begin
          if (cnt_q[i] != 2'd0) cnt_d[i] = cnt_q[i] - 2'd1;
        end
      end else begin
        cnt_d[i] = 2'd0;
      end
    end
  end

  // Pending-counter state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < 32; i++) cnt_q[i] <= 2'd0;
    end else begin
      for (int i = 0; i < 32; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Busy vector straight from the counters; x0 is never busy.
  always_comb begin
    o_busy = '0;
    for (int i = 1; i < 32; i++) o_busy[i] = (cnt_q[i] != 2'd0);
  end

`ifdef WB_BYPASS_EN
  // Forward the write on the port this cycle so a same-cycle read is not stale.
  always_comb begin
    o_fwd1_valid = 1'b0;
    o_fwd1_data  = '0;
    o_fwd2_valid = 1'b0;
    o_fwd2_data  = '0;
    if (wen_q && (wnum_q != 5'd0) && (i_Rnum1 == wnum_q)) begin
      o_fwd1_valid = 1'b1;
      o_fwd1_data  = wd_q;
    end
    if (wen_q && (wnum_q != 5'd0) && (i_Rnum2 == wnum_q)) begin
      o_fwd2_valid = 1'b1;
      o_fwd2_data  = wd_q;
    end
  end
`endif

endmodule
